// File: rtl/sync_debouncer.sv
// Multi-channel input conditioner: N-flop synchroniser, per-channel debounce counter, registered edge pulses.
// Build option SYNC_DEBOUNCER_EDGE_EN enables rise_pulse/fall_pulse/changed; otherwise they are tied to 0.
module sync_debouncer #(
    parameter int DIGITS          = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIGITS-1:0] data_in,
    output logic [DIGITS-1:0] data_out,
    output logic [DIGITS-1:0] rise_pulse,
    output logic [DIGITS-1:0] fall_pulse,
    output logic              changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DIGITS-1:0] sync_q [SYNC_STAGES];
    logic [DIGITS-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0]  cnt_q  [DIGITS];
    logic [CNT_W-1:0]  cnt_d  [DIGITS];
    logic [DIGITS-1:0] data_out_q;
    logic [DIGITS-1:0] data_out_d;
    logic [DIGITS-1:0] sample;

    always_comb begin
        sync_d[0] = data_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    // A level is accepted only on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
    always_comb begin
        data_out_d = data_out_q;
        for (int i = 0; i < DIGITS; i++) begin
            cnt_d[i] = '0;
            if (sample[i] != data_out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    data_out_d[i] = sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < DIGITS; i++) begin
                cnt_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < DIGITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

`ifdef SYNC_DEBOUNCER_EDGE_EN
    logic [DIGITS-1:0] rise_q;
    logic [DIGITS-1:0] rise_d;
    logic [DIGITS-1:0] fall_q;
    logic [DIGITS-1:0] fall_d;
    logic              changed_q;
    logic              changed_d;

    // Pulses are computed from the next data_out so they land in its update cycle.
    always_comb begin
        rise_d    = data_out_d & ~data_out_q;
        fall_d    = ~data_out_d & data_out_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign changed    = changed_q;
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
    assign changed    = 1'b0;
`endif

endmodule
